// File: rtl/bit_stuffer.sv
// Transmit-side bit stuffer: inserts a 0 after MAX_ONES consecutive counted 1s,
// skipping the first SKIP_BITS packet bits. Optional macro STUFF_STATS_EN adds stuff_count.
module bit_stuffer #(
    parameter int MAX_ONES  = 6,
    parameter int SKIP_BITS = 8,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       abort,
    input  logic       s_in,
    input  logic       start_stuffer,
    input  logic       end_stuffer,
    output logic       stuff_stall,
    output logic       s_out,
    output logic       start_nrzi,
    output logic       end_nrzi
`ifdef STUFF_STATS_EN
    ,
    output logic [7:0] stuff_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        TAIL   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_ONES);
    localparam logic [CNT_W-1:0] SKIP_C = CNT_W'(SKIP_BITS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   pos_q, pos_d;
    logic [CNT_W-1:0]   ones_q, ones_d;
    logic               s_out_q, s_out_d;
    logic               start_q, start_d;
    logic               end_q, end_d;

    logic               consume;
    logic               counted;
    logic [CNT_W-1:0]   ones_inc;
    logic [CNT_W-1:0]   pos_inc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            ones_q  <= '0;
            s_out_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            ones_q  <= ones_d;
            s_out_q <= s_out_d;
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    // Output logic: stall is combinational so upstream freezes in the same cycle
    always_comb begin
        stuff_stall = 1'b0;
        if (!abort) begin
            case (state_q)
                ACTIVE:  stuff_stall = (ones_q == MAX_C);
                TAIL:    stuff_stall = 1'b1;
                default: stuff_stall = 1'b0;
            endcase
        end
    end

    assign s_out      = s_out_q;
    assign start_nrzi = start_q;
    assign end_nrzi   = end_q;

    assign consume  = !abort && (((state_q == IDLE) && start_stuffer) ||
                                 ((state_q == ACTIVE) && !stuff_stall));
    assign counted  = (pos_q == SKIP_C);
    assign ones_inc = (counted && s_in) ? ones_q + 1'b1 : '0;
    assign pos_inc  = counted ? pos_q : pos_q + 1'b1;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        ones_d  = ones_q;
        s_out_d = 1'b0;
        start_d = 1'b0;
        end_d   = 1'b0;
        if (abort) begin
            state_d = IDLE;
            pos_d   = '0;
            ones_d  = '0;
        end else if (consume) begin
            s_out_d = s_in;
            start_d = (state_q == IDLE);
            pos_d   = pos_inc;
            ones_d  = ones_inc;
            state_d = ACTIVE;
            if (end_stuffer) begin
                // A last bit that completes a run still owes a trailing stuff 0
                if (ones_inc == MAX_C) begin
                    state_d = TAIL;
                end else begin
                    end_d   = 1'b1;
                    state_d = IDLE;
                    pos_d   = '0;
                    ones_d  = '0;
                end
            end
        end else if (stuff_stall) begin
            s_out_d = 1'b0;
            ones_d  = '0;
            if (state_q == TAIL) begin
                end_d   = 1'b1;
                state_d = IDLE;
                pos_d   = '0;
            end
        end
    end

`ifdef STUFF_STATS_EN
    logic [7:0] stuff_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuff_count_q <= 8'd0;
        end else if (abort) begin
            stuff_count_q <= 8'd0;
        end else if (consume && (state_q == IDLE)) begin
            stuff_count_q <= 8'd0;
        end else if (stuff_stall && (stuff_count_q != 8'hFF)) begin
            stuff_count_q <= stuff_count_q + 8'd1;
        end
    end

    assign stuff_count = stuff_count_q;
`endif

endmodule

// File: tb/tb_bit_stuffer.sv
// Directed table-driven bench for bit_stuffer (default parameters MAX_ONES=6, SKIP_BITS=8).
module tb_bit_stuffer;

    logic clk = 1'b0;
    logic rst, abort, s_in, start_stuffer, end_stuffer;
    logic stuff_stall, s_out, start_nrzi, end_nrzi;
`ifdef STUFF_STATS_EN
    logic [7:0] stuff_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic r, a, s, st, en;
        logic e_stall, e_out, e_sn, e_en;
        int   e_cnt;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    bit_stuffer dut (
        .clk          (clk),
        .rst          (rst),
        .abort        (abort),
        .s_in         (s_in),
        .start_stuffer(start_stuffer),
        .end_stuffer  (end_stuffer),
        .stuff_stall  (stuff_stall),
        .s_out        (s_out),
        .start_nrzi   (start_nrzi),
        .end_nrzi     (end_nrzi)
`ifdef STUFF_STATS_EN
        ,
        .stuff_count  (stuff_count)
`endif
    );

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    function automatic void pv(input logic r, a, s, st, en, est, eo, esn, een, input int ec = -1);
        vec_t v;
        v.r = r; v.a = a; v.s = s; v.st = st; v.en = en;
        v.e_stall = est; v.e_out = eo; v.e_sn = esn; v.e_en = een; v.e_cnt = ec;
        vq.push_back(v);
    endfunction

    // PID of eight zeros; first bit carries start_stuffer
    function automatic void pid0(input int ec0 = -1);
        for (int k = 0; k < 8; k++)
            pv(0, 0, 0, k == 0, 0, 0, 0, k == 0, 0, (k == 0) ? ec0 : -1);
    endfunction

    function automatic void ones_run(input int n);
        for (int k = 0; k < n; k++) pv(0, 0, 1, 0, 0, 0, 1, 0, 0);
    endfunction

    function automatic void idle(input int ec = -1);
        pv(0, 0, 0, 0, 0, 0, 0, 0, 0, ec);
    endfunction

    // 0xFF PID then 0101: output mirrors input, never stalls
    function automatic void pkt_ff0101(input int ec0 = -1);
        for (int k = 0; k < 8; k++)
            pv(0, 0, 1, k == 0, 0, 0, 1, k == 0, 0, (k == 0) ? ec0 : -1);
        pv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        pv(0, 0, 1, 0, 0, 0, 1, 0, 0);
        pv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        pv(0, 0, 1, 0, 1, 0, 1, 0, 1);
    endfunction

    initial begin
        rst = 1'b1; abort = 1'b0; s_in = 1'b0; start_stuffer = 1'b0; end_stuffer = 1'b0;
        #1;
        chk("reset_s_out", -1, {7'd0, s_out}, 8'd0);
        chk("reset_start", -1, {7'd0, start_nrzi}, 8'd0);
        chk("reset_end", -1, {7'd0, end_nrzi}, 8'd0);
        chk("reset_stall", -1, {7'd0, stuff_stall}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset pulsed mid-packet after 5 counted ones
        idle();
        pid0();
        ones_run(5);
        pv(1, 0, 1, 0, 0, 0, 0, 0, 0);
        idle();

        // PID 0x00, 12 ones, 0 last: two stuffs, 23 output bits
        pid0(0);
        ones_run(6);
        pv(0, 0, 1, 0, 0, 1, 0, 0, 0);
        ones_run(6);
        pv(0, 0, 0, 0, 1, 1, 0, 0, 0);
        pv(0, 0, 0, 0, 1, 0, 0, 0, 1, 2);
        idle(2);
        idle(2);

        pkt_ff0101(0);
        idle();

        // Trailing stuff 0 in TAIL; start during TAIL held and accepted next cycle
        pid0();
        for (int k = 0; k < 5; k++) pv(0, 0, 1, 0, 0, 0, 1, 0, 0);
        pv(0, 0, 1, 0, 1, 0, 1, 0, 0);
        pv(0, 0, 1, 1, 1, 1, 0, 0, 1, 1);
        pv(0, 0, 1, 1, 1, 0, 1, 1, 1, 0);
        idle();

        // Abort in the stall cycle: no stuff 0, no end_nrzi
        pid0();
        ones_run(6);
        pv(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        pkt_ff0101();
        idle();

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].r; abort = vq[i].a; s_in = vq[i].s;
            start_stuffer = vq[i].st; end_stuffer = vq[i].en;
            #1;
            chk("stuff_stall", i, {7'd0, stuff_stall}, {7'd0, vq[i].e_stall});
            if (vq[i].r) begin
                chk("rst_s_out", i, {7'd0, s_out}, 8'd0);
                chk("rst_start_nrzi", i, {7'd0, start_nrzi}, 8'd0);
                chk("rst_end_nrzi", i, {7'd0, end_nrzi}, 8'd0);
            end
            @(posedge clk);
            #1;
            chk("s_out", i, {7'd0, s_out}, {7'd0, vq[i].e_out});
            chk("start_nrzi", i, {7'd0, start_nrzi}, {7'd0, vq[i].e_sn});
            chk("end_nrzi", i, {7'd0, end_nrzi}, {7'd0, vq[i].e_en});
`ifdef STUFF_STATS_EN
            if (vq[i].e_cnt >= 0)
                chk("stuff_count", i, stuff_count, 8'(vq[i].e_cnt));
`endif
            $display("vec %0d: rst=%0b ab=%0b s=%0b st=%0b en=%0b -> stall=%0b out=%0b sn=%0b en=%0b",
                     i, vq[i].r, vq[i].a, vq[i].s, vq[i].st, vq[i].en,
                     stuff_stall, s_out, start_nrzi, end_nrzi);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
